// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master slice.
// Source-stage words are kept here so the bench and the source agree.
package spi_pkg;

   localparam int DW_DEF = 12;

   localparam logic [11:0] SRC_MASTER_WORD = 12'h702;
   localparam logic [11:0] SRC_SLAVE_WORD  = 12'hE6C;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT_LO,
      SHIFT_HI,
      HOLD
   } state_t;

endpackage

// File: rtl/spi_sclk_tick.sv
// Half-period counter for SCLK generation.
// Held at zero while clr is high; tick marks the last cycle of a phase.
module spi_sclk_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick,
   output logic phase0
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick   = (cnt == LAST);
   assign phase0 = (cnt == '0);

endmodule

// File: rtl/spi_master_12.sv
// SPI mode-0 master, MSB first, one word per start request.
// Pins are registered decodes of the state, so they trail it by one clk.
module spi_master_12
   import spi_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int CLK_DIV = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] tx_dat,
   output logic [DW-1:0] rx_dat,
   output logic          busy,
   output logic          done,
   output logic          sclk,
   output logic          cs_n,
   output logic          mosi,
   input  logic          miso
);

   localparam int BW = $clog2(DW + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

   state_t        state;
   state_t        state_nx;
   logic          tick;
   logic          phase0;
   logic          is_idle;
   logic          last_bit;
   logic [DW-1:0] tx_sh;
   logic [DW-1:0] rx_sh;
   logic [BW-1:0] bit_cnt;

   assign is_idle  = (state == IDLE);
   assign last_bit = (bit_cnt == LAST_BIT);

   spi_sclk_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (is_idle),
      .tick   (tick),
      .phase0 (phase0)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:     if (start) state_nx = SETUP;
         SETUP:    if (tick)  state_nx = SHIFT_HI;
         SHIFT_HI: if (tick)  state_nx = last_bit ? HOLD : SHIFT_LO;
         SHIFT_LO: if (tick)  state_nx = SHIFT_HI;
         HOLD:     if (tick)  state_nx = IDLE;
         default:             state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_sh   <= '0;
         rx_sh   <= '0;
         bit_cnt <= '0;
      end else if (is_idle) begin
         bit_cnt <= '0;
         if (start) tx_sh <= tx_dat;
      end else begin
         // phase0 of SHIFT_HI is the clk edge that raises sclk
         if (state == SHIFT_HI && phase0) begin
            rx_sh <= {rx_sh[DW-2:0], miso};
         end
         if (state == SHIFT_HI && tick) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (!last_bit) tx_sh <= {tx_sh[DW-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_dat <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         sclk   <= 1'b0;
         cs_n   <= 1'b1;
         mosi   <= 1'b0;
      end else begin
         busy <= !is_idle;
         cs_n <= is_idle;
         sclk <= (state == SHIFT_HI);
         mosi <= is_idle ? 1'b0 : tx_sh[DW-1];
         // busy still high while state is IDLE marks the end of a transfer
         done <= is_idle && busy;
         if (is_idle && busy) rx_dat <= rx_sh;
      end
   end

endmodule

// File: tb/tb_spi_master_12.sv
// Directed bench for spi_master_12 with a scoreboard of expected words.
// Two instances: default CLK_DIV=4 and a CLK_DIV=2 build.
module tb_spi_master_12;
   import spi_pkg::*;

   typedef struct {
      logic [11:0] rx;
      int          at;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, start2;
   logic [11:0] tx, tx2;
   logic [11:0] rx_dat, rx_dat2;
   logic        busy, done, sclk, cs_n, mosi, miso;
   logic        busy2, done2, sclk2, cs_n2, mosi2;
   logic        loop;
   logic [11:0] slave_sr = '0;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   t0;
   exp_t sb[$];
   exp_t sb2[$];
   exp_t e;
   exp_t e2;

   int          rise_cnt, cs_first, cs_last;
   logic [11:0] mosi_seq;
   logic        sclk_p = 1'b0;
   logic        cs_p = 1'b1;
   int          rise2, last_rise2, period2;
   logic        sclk2_p = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign miso = loop ? mosi : slave_sr[11];

   always @(negedge cs_n) slave_sr = SRC_SLAVE_WORD;
   always @(negedge sclk) if (!cs_n) slave_sr = {slave_sr[10:0], 1'b0};

   spi_master_12 dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .tx_dat (tx),
      .rx_dat (rx_dat),
      .busy   (busy),
      .done   (done),
      .sclk   (sclk),
      .cs_n   (cs_n),
      .mosi   (mosi),
      .miso   (miso)
   );

   spi_master_12 #(.CLK_DIV(2)) dut2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start2),
      .tx_dat (tx2),
      .rx_dat (rx_dat2),
      .busy   (busy2),
      .done   (done2),
      .sclk   (sclk2),
      .cs_n   (cs_n2),
      .mosi   (mosi2),
      .miso   (mosi2)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      rise_cnt   = 0;
      mosi_seq   = '0;
      cs_first   = -1;
      cs_last    = -1;
      rise2      = 0;
      last_rise2 = -1;
      period2    = -1;
   endtask

   task automatic drain(input int budget);
      int i = 0;
      while ((sb.size() != 0 || sb2.size() != 0) && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk("drain_timeout", 32'(sb.size() + sb2.size()), 0);
      repeat (3) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (sclk && !sclk_p) begin
         rise_cnt++;
         mosi_seq = {mosi_seq[10:0], mosi};
      end
      if (!cs_n && cs_p) cs_first = cyc;
      if (!cs_n) cs_last = cyc;
      if (done) begin
         chk("done_with_busy", 32'(busy), 0);
         if (sb.size() == 0) begin
            chk("spurious_done", 32'(done), 0);
         end else begin
            e = sb.pop_front();
            chk("rx_dat", 32'(rx_dat), 32'(e.rx));
            chk("done_cyc", cyc, e.at);
         end
      end
      if (sclk2 && !sclk2_p) begin
         rise2++;
         if (last_rise2 >= 0) period2 = cyc - last_rise2;
         last_rise2 = cyc;
      end
      if (done2) begin
         chk("done2_with_busy", 32'(busy2), 0);
         if (sb2.size() == 0) begin
            chk("spurious_done2", 32'(done2), 0);
         end else begin
            e2 = sb2.pop_front();
            chk("rx_dat2", 32'(rx_dat2), 32'(e2.rx));
            chk("done2_cyc", cyc, e2.at);
         end
      end
      sclk_p  = sclk;
      cs_p    = cs_n;
      sclk2_p = sclk2;
   end

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      start2 = 1'b0;
      tx     = '0;
      tx2    = '0;
      loop   = 1'b1;
      clear_stats();
      repeat (3) @(negedge clk);
      chk("rst_sclk", 32'(sclk), 0);
      chk("rst_cs_n", 32'(cs_n), 1);
      chk("rst_mosi", 32'(mosi), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rx", 32'(rx_dat), 0);
      chk("rst_cs_n2", 32'(cs_n2), 1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // loopback with the source word
      clear_stats();
      tx = SRC_MASTER_WORD;
      start = 1'b1;
      t0 = cyc + 1;
      sb.push_back('{SRC_MASTER_WORD, t0 + 101});
      @(negedge clk);
      start = 1'b0;
      drain(150);
      chk("rise_cnt", rise_cnt, 12);
      chk("cs_first", cs_first, t0 + 1);
      chk("cs_last", cs_last, t0 + 100);

      // slave model drives its own word
      loop = 1'b0;
      clear_stats();
      start = 1'b1;
      t0 = cyc + 1;
      sb.push_back('{SRC_SLAVE_WORD, t0 + 101});
      @(negedge clk);
      start = 1'b0;
      drain(150);
      chk("mosi_seq", 32'(mosi_seq), 32'(12'b0111_0000_0010));

      // second start and tx change while busy
      clear_stats();
      start = 1'b1;
      t0 = cyc + 1;
      sb.push_back('{SRC_SLAVE_WORD, t0 + 101});
      @(negedge clk);
      start = 1'b0;
      while (cyc < t0 + 39) @(negedge clk);
      start = 1'b1;
      tx = 12'hFFF;
      @(negedge clk);
      start = 1'b0;
      drain(150);
      chk("ign_mosi_seq", 32'(mosi_seq), 32'(12'b0111_0000_0010));
      chk("ign_rise_cnt", rise_cnt, 12);
      repeat (110) @(negedge clk);
      chk("ign_rx_hold", 32'(rx_dat), 32'(SRC_SLAVE_WORD));

      // reset mid-transfer
      loop = 1'b1;
      tx = SRC_MASTER_WORD;
      clear_stats();
      start = 1'b1;
      t0 = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < t0 + 49) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_cs_n", 32'(cs_n), 1);
      chk("abort_sclk", 32'(sclk), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_rx", 32'(rx_dat), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      tx = 12'h3C5;
      clear_stats();
      start = 1'b1;
      t0 = cyc + 1;
      sb.push_back('{12'h3C5, t0 + 101});
      @(negedge clk);
      start = 1'b0;
      drain(150);

      // start held high: back-to-back transfers
      tx = 12'hA5A;
      start = 1'b1;
      t0 = cyc + 1;
      sb.push_back('{12'hA5A, t0 + 101});
      sb.push_back('{12'hA5A, t0 + 202});
      while (cyc < t0 + 101) @(negedge clk);
      chk("gap_cs_hi", 32'(cs_n), 1);
      chk("gap_busy", 32'(busy), 0);
      start = 1'b0;
      @(negedge clk);
      chk("gap_cs_relow", 32'(cs_n), 0);
      drain(250);

      // CLK_DIV=2 build
      clear_stats();
      tx2 = 12'h001;
      start2 = 1'b1;
      t0 = cyc + 1;
      sb2.push_back('{12'h001, t0 + 51});
      @(negedge clk);
      start2 = 1'b0;
      drain(100);
      chk("rise2_cnt", rise2, 12);
      chk("sclk2_period", period2, 4);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
